uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte stream among NUM_SRC AXI-stream sources.
// Optional per-packet header byte {HDR_TAG, source index} is enabled by defining UART_TX_ARB_HEADER_EN.
module uart_tx_arbiter #(
  parameter int          NUM_SRC     = 4,
  parameter int          MAX_PKT_LEN = 256,
  parameter logic [3:0]  HDR_TAG     = 4'hA
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [8*NUM_SRC-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]     s_tvalid,
  input  logic [NUM_SRC-1:0]     s_tlast,
  output logic [NUM_SRC-1:0]     s_tready,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy,
  output logic                   err_overlong
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = (MAX_PKT_LEN == 0) ? 1 : $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);

`ifdef UART_TX_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

  state_t               state, state_nxt;
  logic [NUM_SRC-1:0]   grant_nxt;
  logic [IDX_W-1:0]     gidx, gidx_nxt;
  logic [IDX_W-1:0]     last, last_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 err_nxt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_hit;

  // Scan from farthest to nearest so the requester closest after 'last' wins.
  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      if (s_tvalid[(int'(last) + i) % NUM_SRC]) begin
        arb_idx = IDX_W'((int'(last) + i) % NUM_SRC);
        arb_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    last_nxt  = last;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    s_tready  = '0;
    case (state)
      IDLE: begin
        if (arb_hit) begin
          grant_nxt          = '0;
          grant_nxt[arb_idx] = 1'b1;
          gidx_nxt           = arb_idx;
          cnt_nxt            = '0;
`ifdef UART_TX_ARB_HEADER_EN
          state_nxt          = HDR;
`else
          state_nxt          = DATA;
`endif
        end
      end
`ifdef UART_TX_ARB_HEADER_EN
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {HDR_TAG, 4'(gidx)};
        if (m_tready) state_nxt = DATA;
      end
`endif
      DATA: begin
        m_tdata        = s_tdata[8*gidx +: 8];
        m_tvalid       = s_tvalid[gidx];
        s_tready[gidx] = m_tready;
        if (s_tvalid[gidx] && m_tready) begin
          // A packet ends on tlast, or is cut at the length limit when tlast is missing.
          if (s_tlast[gidx] || (MAX_PKT_LEN != 0 && cnt == CNT_LAST)) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            last_nxt  = gidx;
            cnt_nxt   = '0;
            err_nxt   = ~s_tlast[gidx];
          end else if (cnt != CNT_SAT) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      grant        <= '0;
      gidx         <= '0;
      last         <= IDX_W'(NUM_SRC - 1);
      cnt          <= '0;
      err_overlong <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      gidx         <= gidx_nxt;
      last         <= last_nxt;
      cnt          <= cnt_nxt;
      err_overlong <= err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed phases plus randomized traffic against a transaction-level reference model.
module tb_uart_tx_arbiter;
  localparam int NUM  = 4;
  localparam int MAXL = 4;
  localparam logic [3:0] TAG = 4'hA;
`ifdef UART_TX_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              areset;
  logic [8*NUM-1:0]  s_tdata;
  logic [NUM-1:0]    s_tvalid, s_tlast, s_tready, grant;
  logic [7:0]        m_tdata;
  logic              m_tvalid, m_tready, busy, err_overlong;

  always #5 aclk = ~aclk;

  uart_tx_arbiter #(.NUM_SRC(NUM), .MAX_PKT_LEN(MAXL), .HDR_TAG(TAG)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant(grant), .busy(busy), .err_overlong(err_overlong)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] srcq [NUM][$];
  logic [7:0] obs[$];
  logic [7:0] exp_q[$];
  int err_seen = 0;
  int gap_pct = 0;
  logic [NUM-1:0] vld_d, last_d;
  logic [7:0] dat_d [NUM];

  // Reference model: 0 = idle, 1 = header, 2 = streaming packet of 'mown'.
  int ms, mown, mlast, mcnt;
  bit merr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mown = 0; mlast = NUM - 1; mcnt = 0; merr = 1'b0;
  endtask

  function automatic bit drained();
    bit e = (ms == 0);
    for (int i = 0; i < NUM; i++) if (srcq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic step(input bit rst, input bit rdy, input bit do_chk);
    logic [NUM-1:0] eg, er;
    logic ev;
    logic [7:0] ed;
    bit hs, lastb;
    @(negedge aclk);
    areset = rst;
    m_tready = rdy;
    for (int i = 0; i < NUM; i++) begin
      if (srcq[i].size() > 0) begin
        dat_d[i]  = srcq[i][0][7:0];
        last_d[i] = srcq[i][0][8];
        vld_d[i]  = ($urandom_range(99) >= gap_pct);
      end else begin
        dat_d[i]  = 8'($urandom);
        last_d[i] = 1'($urandom);
        vld_d[i]  = 1'b0;
      end
      s_tdata[8*i +: 8] = dat_d[i];
    end
    s_tvalid = vld_d;
    s_tlast  = last_d;
    eg = '0; er = '0; ev = 1'b0; ed = 8'h00;
    if (ms != 0) eg[mown] = 1'b1;
    if (ms == 1) begin
      ev = 1'b1;
      ed = {TAG, 4'(mown)};
    end else if (ms == 2) begin
      ev = vld_d[mown];
      ed = dat_d[mown];
      if (rdy) er[mown] = 1'b1;
    end
    #1;
    if (do_chk) begin
      chk("m_tvalid", 32'(m_tvalid), 32'(ev));
      chk("m_tdata", 32'(m_tdata), 32'(ed));
      chk("s_tready", 32'(s_tready), 32'(er));
      chk("grant", 32'(grant), 32'(eg));
      chk("busy", 32'(busy), 32'(ms != 0));
      chk("err_overlong", 32'(err_overlong), 32'(merr));
    end
    if (m_tvalid === 1'b1 && m_tready) obs.push_back(m_tdata);
    if (err_overlong === 1'b1) err_seen++;
    @(posedge aclk);
    hs = (ms == 2) && vld_d[mown] && rdy;
    lastb = last_d[mown];
    if (hs) void'(srcq[mown].pop_front());
    if (rst) begin
      model_reset();
      return;
    end
    merr = 1'b0;
    case (ms)
      0: begin
        for (int k = 1; k <= NUM; k++) begin
          if (vld_d[(mlast + k) % NUM]) begin
            mown = (mlast + k) % NUM;
            ms = HDR_EN ? 1 : 2;
            mcnt = 0;
            break;
          end
        end
      end
      1: if (rdy) ms = 2;
      default: begin
        if (hs) begin
          mcnt++;
          if (lastb) begin
            ms = 0; mlast = mown;
          end else if (MAXL != 0 && mcnt == MAXL) begin
            ms = 0; mlast = mown; merr = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic drain(input string tag, input int budget, input int rdy_pct);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (drained()) begin done = 1'b1; break; end
      step(1'b0, $urandom_range(99) < rdy_pct, 1'b1);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic push_pkt(input int s, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) srcq[s].push_back({k == n - 1, 8'(base + 8'(k))});
  endtask

  task automatic exp_hdr(input int s);
    if (HDR_EN) exp_q.push_back({TAG, 4'(s)});
  endtask

  task automatic exp_bytes(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(base + 8'(k)));
  endtask

  task automatic cmp_obs(input string tag);
    chk($sformatf("%s_len", tag), 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [3:0] pat;
    bit done;
    pat = 4'b1001;
    areset = 1'b1; m_tready = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0;
    model_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    obs.delete();

    // Single source packet
    srcq[1].push_back({1'b0, 8'h11});
    srcq[1].push_back({1'b0, 8'h22});
    srcq[1].push_back({1'b1, 8'h33});
    exp_hdr(1); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    drain("p1_drain", 50, 100);
    cmp_obs("p1");

    // Rotation from a fresh reset
    step(1'b1, 1'b1, 1'b1);
    obs.delete();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NUM; s++) begin
        push_pkt(s, 2, 8'(s * 16 + p * 2));
        exp_hdr(s); exp_bytes(2, 8'(s * 16 + p * 2));
      end
    drain("p2_drain", 100, 100);
    cmp_obs("p2");

    // Backpressure on src2
    push_pkt(2, 4, 8'hB0);
    exp_hdr(2); exp_bytes(4, 8'hB0);
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (drained()) begin done = 1'b1; break; end
      step(1'b0, pat[c % 4], 1'b1);
    end
    chk("p3_drain", 32'(done), 32'd1);
    cmp_obs("p3");

    // Overlong packet is cut after MAXL beats
    err_seen = 0;
    push_pkt(0, 6, 8'hC1);
    exp_hdr(0); exp_bytes(4, 8'hC1); exp_hdr(0); exp_bytes(2, 8'hC5);
    drain("p4_drain", 60, 100);
    chk("p4_err_count", 32'(err_seen), 32'd1);
    cmp_obs("p4");

    // Reset in the middle of src1's packet
    push_pkt(1, 5, 8'hD1);
    done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (srcq[1].size() == 3) begin done = 1'b1; break; end
      step(1'b0, 1'b1, 1'b1);
    end
    chk("p5_reach_beat2", 32'(done), 32'd1);
    srcq[0].push_back({1'b1, 8'hE0});
    srcq[2].push_back({1'b1, 8'hF0});
    obs.delete();
    step(1'b1, 1'b1, 1'b1);
    exp_q.push_back(8'hD3);
    exp_hdr(0); exp_q.push_back(8'hE0);
    exp_hdr(1); exp_q.push_back(8'hD4); exp_q.push_back(8'hD5);
    exp_hdr(2); exp_q.push_back(8'hF0);
    drain("p5_drain", 60, 100);
    cmp_obs("p5");

    // Header byte and an exactly-MAXL packet that must not be flagged
    err_seen = 0;
    srcq[3].push_back({1'b1, 8'h55});
    exp_hdr(3); exp_q.push_back(8'h55);
    drain("p6a_drain", 30, 100);
    cmp_obs("p6a");
    push_pkt(1, 4, 8'h61);
    exp_hdr(1); exp_bytes(4, 8'h61);
    drain("p6b_drain", 30, 100);
    chk("p6_err_count", 32'(err_seen), 32'd0);
    cmp_obs("p6b");

    // Randomized traffic with valid gaps and backpressure
    gap_pct = 20;
    for (int r = 0; r < 600; r++) begin
      if ($urandom_range(5) == 0) begin
        int s;
        s = int'($urandom_range(NUM - 1));
        push_pkt(s, int'($urandom_range(1, 7)), 8'($urandom));
      end
      step(1'b0, $urandom_range(99) < 70, 1'b1);
    end
    drain("p7_drain", 3000, 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
